// File: rtl/arb3_pkg.sv
// arb3_pkg: shared types and helpers for the three-client round-robin arbiter.
//   N_REQ         number of clients
//   idx_t         client index / pointer type (values 0..2)
//   arb_state_e   arbiter FSM states (IDLE, GRANT)
//   next_idx()    modulo-3 increment of a client index
//   idx_onehot()  client index to one-hot grant vector
package arb3_pkg;

  localparam int N_REQ = 3;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Index 3 is never produced by the design; it folds onto 0 so that a
  // corrupted pointer can never select a non-existent client.
  function automatic idx_t next_idx(input idx_t i);
    idx_t r;
    case (i)
      2'd0:    r = 2'd1;
      2'd1:    r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  function automatic logic [N_REQ-1:0] idx_onehot(input idx_t i);
    logic [N_REQ-1:0] r;
    case (i)
      2'd0:    r = 3'b001;
      2'd1:    r = 3'b010;
      2'd2:    r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rr_pick3: combinational round-robin selector for three requesters.
// The search starts at ptr and walks ptr, ptr+1, ptr+2 (mod 3); the first
// requesting client wins.
//   req    [2:0]  request bits, one per client
//   ptr    [1:0]  highest-priority client for this pick
//   valid         at least one request present
//   idx    [1:0]  winning client (equals the start point when valid=0)
import arb3_pkg::*;

module rr_pick3 (
  input  logic [N_REQ-1:0] req,
  input  idx_t             ptr,
  output logic             valid,
  output idx_t             idx
);

  idx_t first_idx;
  idx_t second_idx;
  idx_t third_idx;

  // Rotation order derived from the pointer; an out-of-range pointer is
  // treated as 0.
  always_comb begin
    first_idx  = (ptr == 2'd3) ? 2'd0 : ptr;
    second_idx = next_idx(first_idx);
    third_idx  = next_idx(second_idx);
  end

  always_comb begin
    valid = |req;
    idx   = first_idx;
    if (req[first_idx]) begin
      idx = first_idx;
    end else if (req[second_idx]) begin
      idx = second_idx;
    end else if (req[third_idx]) begin
      idx = third_idx;
    end
  end

endmodule

// File: rtl/arb3_rr.sv
// arb3_rr: three-requester round-robin arbiter with registered one-hot grant.
// A grant is held until the owner pulses done, drops its request, or the
// hold limit expires. Every release returns to IDLE, so there is always at
// least one cycle with gnt=000 between two owners.
//
// Handshake: req[i] is a level; a client owns the resource while gnt[i]=1.
// The owner ends its tenure either by asserting done for one cycle or by
// dropping req[i]; both are sampled on the rising edge and gnt falls on the
// following cycle. done is meaningless while no grant is active.
//
// Ports:
//   ck         clock, rising edge
//   rst        asynchronous active-high reset
//   req  [2:0] level-sensitive request per client
//   done       release strobe from the current owner
//   gnt  [2:0] registered one-hot grant (or zero)
//   busy       registered OR of gnt
//   timeout    one-cycle pulse after a forced release
//   owner[1:0] current or most recent grantee, 0 after reset
//   dbg_state  current FSM state, for observation only
import arb3_pkg::*;

module arb3_rr #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             timeout,
  output idx_t             owner,
  output arb_state_e       dbg_state
);

  generate
    if (MAX_HOLD < 0 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param
      $error("arb3_rr: CNT_W too small for MAX_HOLD");
    end
  endgenerate

  // Hold limit compare value; unused when the timeout is disabled.
  localparam bit               HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  arb_state_e       state_q,   state_d;
  logic [N_REQ-1:0] gnt_q,     gnt_d;
  logic             busy_q,    busy_d;
  logic             timeout_q, timeout_d;
  idx_t             owner_q,   owner_d;
  idx_t             ptr_q,     ptr_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;

  logic             pick_valid;
  idx_t             pick_idx;

  rr_pick3 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      owner_q   <= 2'd0;
      ptr_q     <= 2'd0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          gnt_d   = idx_onehot(pick_idx);
          busy_d  = 1'b1;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end

      GRANT: begin
        // Release priority: done, then abandoned request, then hold limit.
        // Only the hold-limit path raises timeout, so done on the limit
        // edge releases silently.
        if (done || !req[owner_q] || (HOLD_EN && cnt_q == HOLD_LAST)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          busy_d    = 1'b0;
          ptr_d     = next_idx(owner_q);
          timeout_d = !done && req[owner_q];
        end else if (cnt_q != CNT_MAX) begin
          // Saturates so an unlimited hold never wraps.
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
  assign owner     = owner_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_arb3_rr.sv
// tb_arb3_rr: scoreboard bench for arb3_rr. Instance A uses a hold limit of
// 4, instance B disables the limit. A behavioural model predicts each
// cycle's outputs from the arbitration rules; a monitor compares.
module tb_arb3_rr;
  import arb3_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [2:0]       req_a, req_b;
  logic             done_a, done_b;
  logic [2:0]       gnt_a, gnt_b;
  logic             busy_a, busy_b;
  logic             timeout_a, timeout_b;
  idx_t             owner_a, owner_b;
  arb_state_e       state_a, state_b;

  arb3_rr #(.MAX_HOLD(4), .CNT_W(5)) dut_a (
    .ck(clk), .rst(rst), .req(req_a), .done(done_a),
    .gnt(gnt_a), .busy(busy_a), .timeout(timeout_a), .owner(owner_a),
    .dbg_state(state_a)
  );

  arb3_rr #(.MAX_HOLD(0), .CNT_W(5)) dut_b (
    .ck(clk), .rst(rst), .req(req_b), .done(done_b),
    .gnt(gnt_b), .busy(busy_b), .timeout(timeout_b), .owner(owner_b),
    .dbg_state(state_b)
  );

  int total = 0;
  int bad   = 0;

  // Expected word: {gnt[2:0], busy, timeout, owner[1:0]}
  logic [6:0] exp_a_q[$];
  logic [6:0] exp_b_q[$];

  // ---------------- reference model ----------------
  // Per unit: whether someone holds the resource, who, how many cycles the
  // grant has been visible, and which client is searched first next time.
  bit m_on[2];
  int m_cur[2];
  int m_ten[2];
  int m_first[2];
  int m_lim[2];
  int m_last[2];

  initial begin
    m_lim[0] = 4;
    m_lim[1] = 0;
  end

  function automatic void model_reset(input int u);
    m_on[u]    = 1'b0;
    m_cur[u]   = 0;
    m_ten[u]   = 0;
    m_first[u] = 0;
  endfunction

  function automatic logic [6:0] model_view(input int u, input logic to);
    logic [2:0] g;
    logic [1:0] o;
    g = m_on[u] ? (3'b001 << m_cur[u]) : 3'b000;
    o = 2'(m_cur[u]);
    return {g, m_on[u], to, o};
  endfunction

  function automatic logic [6:0] model_step(input int u, input logic [2:0] r, input logic d);
    logic to;
    bit   found;
    bit   rel;
    int   c;
    to    = 1'b0;
    found = 1'b0;
    rel   = 1'b0;
    if (!m_on[u]) begin
      for (int k = 0; k < 3; k++) begin
        c = (m_first[u] + k) % 3;
        if (!found && r[c]) begin
          found    = 1'b1;
          m_on[u]  = 1'b1;
          m_cur[u] = c;
          m_ten[u] = 1;
        end
      end
    end else if (d) begin
      rel = 1'b1;
    end else if (!r[m_cur[u]]) begin
      rel = 1'b1;
    end else if (m_lim[u] != 0 && m_ten[u] == m_lim[u]) begin
      rel = 1'b1;
      to  = 1'b1;
    end else begin
      m_ten[u] = m_ten[u] + 1;
    end
    if (rel) begin
      m_on[u]    = 1'b0;
      m_first[u] = (m_cur[u] + 1) % 3;
    end
    return model_view(u, to);
  endfunction

  always @(posedge rst) begin
    model_reset(0);
    model_reset(1);
  end

  always @(posedge clk) begin
    if (rst) begin
      model_reset(0);
      model_reset(1);
      exp_a_q.push_back(model_view(0, 1'b0));
      exp_b_q.push_back(model_view(1, 1'b0));
    end else begin
      exp_a_q.push_back(model_step(0, req_a, done_a));
      exp_b_q.push_back(model_step(1, req_b, done_b));
    end
  end

  // ---------------- scoreboard monitor ----------------
  task automatic check_word(input string nm, input logic [6:0] act,
                            input logic [6:0] exp, input bit have);
    total++;
    if (!have) begin
      bad++;
      $display("FAIL %s: no expected entry, got gnt=%b busy=%b to=%b owner=%0d",
               nm, act[6:4], act[3], act[2], act[1:0]);
    end else if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got gnt=%b busy=%b to=%b owner=%0d want gnt=%b busy=%b to=%b owner=%0d",
               nm, $time, act[6:4], act[3], act[2], act[1:0],
               exp[6:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  always @(posedge clk) begin
    logic [6:0] ea, eb;
    bit ha, hb;
    #1;
    ha = (exp_a_q.size() > 0);
    hb = (exp_b_q.size() > 0);
    ea = ha ? exp_a_q.pop_front() : 7'h0;
    eb = hb ? exp_b_q.pop_front() : 7'h0;
    check_word("unit_a", {gnt_a, busy_a, timeout_a, owner_a}, ea, ha);
    check_word("unit_b", {gnt_b, busy_b, timeout_b, owner_b}, eb, hb);
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_async_reset();
    total++;
    if (gnt_a !== 3'b000 || busy_a !== 1'b0 || timeout_a !== 1'b0 || owner_a !== 2'd0 ||
        gnt_b !== 3'b000 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got a gnt=%b busy=%b to=%b owner=%0d b gnt=%b busy=%b want zeros",
               gnt_a, busy_a, timeout_a, owner_a, gnt_b, busy_b);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst    = 1'b1;
    req_a  = 3'b000;
    req_b  = 3'b000;
    done_a = 1'b0;
    done_b = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(2);

    // Rotation with done pulsed on every grant; B holds forever.
    req_a = 3'b111;
    req_b = 3'b001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) done_a = 1'b1;
      @(negedge clk) done_a = 1'b0;
    end
    req_a = 3'b000;
    cycles(2);

    // Forced release and regrant for a single requester.
    req_a = 3'b010;
    cycles(12);
    req_a = 3'b000;
    cycles(2);

    // Owner 2 abandons while clients 0 and 1 request.
    req_a = 3'b100;
    cycles(3);
    req_a = 3'b011;
    cycles(4);
    req_a = 3'b000;
    cycles(2);

    // done lands on the same edge as the hold limit.
    req_a = 3'b010;
    cycles(4);
    done_a = 1'b1;
    cycles(1);
    done_a = 1'b0;
    req_a  = 3'b000;
    cycles(2);

    // Asynchronous reset between edges while client 2 is granted.
    req_a = 3'b100;
    cycles(3);
    #2 rst = 1'b1;
    #1 check_async_reset();
    @(negedge clk);
    rst   = 1'b0;
    req_a = 3'b110;
    cycles(4);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) req_a = 3'($urandom_range(0, 7));
      done_a = ($urandom_range(0, 3) == 0);
    end
    done_a = 1'b0;
    req_a  = 3'b000;
    req_b  = 3'b000;
    cycles(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arb3_rr.md
Name: arb3_rr

Overview:
- Three-requester round-robin arbiter.
- Shares a single downstream resource, e.g. a shared 3-input datapath slot or bus port, among three clients.
- Grants are one-hot and registered, held until the owner signals done, withdraws its request, or a hold timeout expires.
- Intended to be synthesised onto the 9-track 3V3 cell set; all state sits in plain D flip-flops with asynchronous clear.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles a grant may be held. 0 disables the timeout.
- CNT_W, 5: hold counter width. Must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- ck  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req  input  3  request bits, one per client; level-sensitive.
- done  input  1  release strobe from the current owner; ignored when no grant is active.
- gnt  output  3  one-hot grant (or all zero); registered.
- busy  output  1  high while any gnt bit is high (the OR of gnt, registered).
- timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD.
- owner  output  2  index of the current or most recent grantee (0..2); 0 after reset.

Behaviour:
- Reset, asynchronous, any time including mid-grant:
  - gnt=000, busy=0, timeout=0, owner=0.
  - State returns to IDLE, hold counter=0, priority pointer=0.
  - The first arbitration after reset gives priority order 0,1,2.
- Two states, IDLE and GRANT.
- IDLE:
  - If req!=000 at an edge, the winner is the first set bit scanning (ptr, ptr+1, ptr+2) mod 3.
  - gnt[winner]=1 and owner=winner from that edge onward; move to GRANT; counter=0.
  - Latency from req sampled to gnt visible is 1 cycle.
  - If req==000, stay in IDLE.
- GRANT, release conditions evaluated at each edge in this priority:
  - (a) done=1 -> normal release.
  - (b) req[owner]=0 -> abandon release.
  - (c) MAX_HOLD!=0 and counter==MAX_HOLD-1 -> forced release; timeout=1 for exactly the following cycle.
  - Otherwise counter+=1 and the grant is held.
- On any release:
  - gnt=000, busy=0, state goes to IDLE, ptr=(owner+1) mod 3.
  - owner keeps its value.
  - A new grant can appear no earlier than 1 cycle after release. This guarantees one dead cycle with gnt=000 between owners, with no back-to-back handover.
- Simultaneous done and timeout condition: done wins and no timeout pulse is produced.
- done while in IDLE is ignored. done is not qualified by client, because only the owner may drive it (system rule).
- A requester that keeps req high after release is re-served only after the other active requesters have each been served once. This is the fairness bound: a waiting requester is granted within 2 grant tenures.
- The hold counter saturates and never wraps. It is cleared on entry to GRANT.
- Invariants:
  - gnt is never multi-hot.
  - busy==|gnt.
  - timeout is never high in two consecutive cycles.

Decomposition:
- Package arb3_pkg holds:
  - the state enum (IDLE, GRANT);
  - N_REQ=3;
  - the pointer/owner index type (2 bits);
  - a function next_idx(i) = (i==2)?0:i+1.
- Sub-module rr_pick3 is purely combinational:
  - inputs req[2:0], ptr[1:0];
  - outputs valid, idx[1:0];
  - it contains the rotate-and-priority-select logic.
- The top module holds the FSM, counter, pointer and output registers.

Test Plan:
- Reset and first grant: assert rst mid-simulation, release, then set req=111. Expect gnt=001 and owner=0 one cycle later; busy=1; timeout=0.
- Rotation: keep req=111 and pulse done at each grant. Expect the gnt sequence 001, (dead), 010, (dead), 100, (dead), 001, with owner 0,1,2,0.
- Timeout: MAX_HOLD=4, req=010, no done. Expect gnt=010 for exactly 4 cycles, then gnt=000 with timeout=1 for one cycle. Because req is still high, gnt=010 is re-granted 1 cycle later.
- Abandon and simultaneity: owner 2 holds; deassert req[2] while req=011. Expect release and next gnt=001. Separately, assert done on the same edge the counter hits MAX_HOLD-1; expect release with timeout=0.
- Async reset mid-grant: rst pulse while gnt=100 and between clock edges. Expect gnt=000, busy=0, owner=0 immediately. After release with req=110, expect gnt=010, since ptr=0 and bit 0 is not requesting.
- MAX_HOLD=0: hold req=001 without done for 100 cycles. Expect gnt to stay 001 and timeout to stay 0 throughout.
